mnist_argmax_collector: RTL and testbench



---
 rtl/mnist_argmax_collector_if.sv | 34 +++
 rtl/mnist_argmax_collector.sv | 117 +++++++++++
 tb/tb_mnist_argmax_collector.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mnist_argmax_collector_if.sv
// Handshake bundle for the argmax collector: prediction stream, label,
// result channel and the statistics counters.
interface mnist_argmax_collector_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] prediction_in;
  logic              prediction_in_valid;
  logic              prediction_in_ready;
  logic [3:0]        label_in;
  logic              label_in_valid;
  logic              label_in_ready;
  logic [3:0]        result_digit;
  logic [DATA_W-1:0] result_max;
  logic              result_correct;
  logic              result_valid;
  logic              result_ready;
  logic              clear_counts;
  logic [15:0]       image_count;
  logic [15:0]       mispred_count;

  modport slave (
    input  prediction_in, prediction_in_valid, label_in, label_in_valid,
           result_ready, clear_counts,
    output prediction_in_ready, label_in_ready, result_digit, result_max,
           result_correct, result_valid, image_count, mispred_count
  );

  modport master (
    output prediction_in, prediction_in_valid, label_in, label_in_valid,
           result_ready, clear_counts,
    input  prediction_in_ready, label_in_ready, result_digit, result_max,
           result_correct, result_valid, image_count, mispred_count
  );
endinterface

// File: rtl/mnist_argmax_collector.sv
// Collects one label plus NUM_CLASSES signed Q8.8 prediction words per image,
// reports the argmax class, its value and whether it matches the label, and
// keeps saturating image / misprediction counters.
//
// state   | meaning
// IDLE    | waiting for the label of the next image
// COLLECT | accepting prediction words, tracking running max and index
// RESULT  | holding the result until the consumer takes it
module mnist_argmax_collector #(
  parameter int DATA_W      = 16,
  parameter int NUM_CLASSES = 10
) (
  input logic                   clock,
  input logic                   reset,
  mnist_argmax_collector_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, RESULT} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  state_t            state;
  logic [3:0]        label_q;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] run_max;
  logic [3:0]        run_idx;
  logic [DATA_W-1:0] next_max;
  logic [3:0]        next_idx;
  logic              pred_fire;
  logic              label_fire;
  logic              result_fire;

  assign pred_fire   = bus.prediction_in_valid & bus.prediction_in_ready;
  assign label_fire  = bus.label_in_valid & bus.label_in_ready;
  assign result_fire = bus.result_valid & bus.result_ready;

  // Running argmax including the word on the bus; index 0 always loads,
  // later words win only when strictly greater so ties keep the lower index.
  always_comb begin
    next_max = run_max;
    next_idx = run_idx;
    if (cnt == 4'd0 || $signed(bus.prediction_in) > $signed(run_max)) begin
      next_max = bus.prediction_in;
      next_idx = cnt;
    end
  end

  // Sequencing FSM with registered readies and result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                   <= IDLE;
      label_q                 <= '0;
      cnt                     <= '0;
      run_max                 <= '0;
      run_idx                 <= '0;
      bus.result_digit        <= '0;
      bus.result_max          <= '0;
      bus.result_correct      <= 1'b0;
      bus.result_valid        <= 1'b0;
      bus.prediction_in_ready <= 1'b0;
      bus.label_in_ready      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.label_in_ready      <= 1'b1;
          bus.prediction_in_ready <= 1'b0;
          if (label_fire) begin
            label_q                 <= bus.label_in;
            cnt                     <= '0;
            bus.label_in_ready      <= 1'b0;
            bus.prediction_in_ready <= 1'b1;
            state                   <= COLLECT;
          end
        end
        COLLECT: begin
          if (pred_fire) begin
            run_max <= next_max;
            run_idx <= next_idx;
            if (cnt == LAST_IDX) begin
              bus.prediction_in_ready <= 1'b0;
              bus.result_valid        <= 1'b1;
              bus.result_digit        <= next_idx;
              bus.result_max          <= next_max;
              // labels above 9 can never be correct
              bus.result_correct      <= (label_q <= 4'd9) && (next_idx == label_q);
              state                   <= RESULT;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        RESULT: begin
          if (result_fire) begin
            bus.result_valid   <= 1'b0;
            bus.label_in_ready <= 1'b1;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Statistics counters: clear beats a coincident result transfer.
  always_ff @(posedge clock) begin
    if (reset || bus.clear_counts) begin
      bus.image_count   <= '0;
      bus.mispred_count <= '0;
    end else if (result_fire) begin
      if (bus.image_count != 16'hFFFF)
        bus.image_count <= bus.image_count + 16'd1;
      if (!bus.result_correct && bus.mispred_count != 16'hFFFF)
        bus.mispred_count <= bus.mispred_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mnist_argmax_collector.sv
// Scoreboard bench for mnist_argmax_collector: expected results are pushed
// when an image is driven and popped when the result channel delivers.
module tb_mnist_argmax_collector;

  typedef logic [15:0] img_t [10];
  typedef struct {
    logic [3:0]  digit;
    logic [15:0] max;
    logic        correct;
  } exp_t;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  int   exp_img;
  int   exp_mis;
  exp_t sb[$];

  mnist_argmax_collector_if #(.DATA_W(16)) bus ();

  mnist_argmax_collector #(.DATA_W(16), .NUM_CLASSES(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic send_label(input logic [3:0] lbl);
    int n = 0;
    @(negedge clock);
    bus.label_in = lbl;
    bus.label_in_valid = 1'b1;
    while (!bus.label_in_ready && n < 200) begin @(negedge clock); n++; end
    if (!bus.label_in_ready) begin
      checks++; failures++;
      $display("FAIL label_timeout: label_in_ready=%b required 1", bus.label_in_ready);
      bus.label_in_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    bus.label_in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    int n = 0;
    repeat (gap) @(negedge clock);
    @(negedge clock);
    bus.prediction_in = w;
    bus.prediction_in_valid = 1'b1;
    while (!bus.prediction_in_ready && n < 200) begin @(negedge clock); n++; end
    if (!bus.prediction_in_ready) begin
      checks++; failures++;
      $display("FAIL word_timeout: prediction_in_ready=%b required 1", bus.prediction_in_ready);
      bus.prediction_in_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    bus.prediction_in_valid = 1'b0;
  endtask

  // Drives a full image and pushes the reference argmax to the scoreboard.
  task automatic send_image(input logic [3:0] lbl, input img_t w, input int gapmax);
    exp_t e;
    logic [15:0] best = w[0];
    logic [3:0]  bi = 4'd0;
    for (int i = 1; i < 10; i++)
      if ($signed(w[i]) > $signed(best)) begin best = w[i]; bi = 4'(i); end
    e.digit = bi;
    e.max = best;
    e.correct = (lbl <= 4'd9) && (bi == lbl);
    sb.push_back(e);
    send_label(lbl);
    for (int i = 0; i < 10; i++) send_word(w[i], (gapmax > 0) ? $urandom_range(0, gapmax) : 0);
  endtask

  task automatic get_result(input int hold, input bit clr, output logic [3:0] d,
                            output logic [15:0] m, output logic c, output bit stable);
    int n = 0;
    stable = 1'b1;
    d = 'x; m = 'x; c = 1'bx;
    @(negedge clock);
    while (!bus.result_valid && n < 200) begin @(negedge clock); n++; end
    if (!bus.result_valid) begin
      checks++; failures++;
      $display("FAIL result_timeout: result_valid=%b required 1", bus.result_valid);
      return;
    end
    d = bus.result_digit; m = bus.result_max; c = bus.result_correct;
    repeat (hold) begin
      @(negedge clock);
      if (bus.result_valid !== 1'b1 || bus.result_digit !== d ||
          bus.result_max !== m || bus.result_correct !== c) stable = 1'b0;
    end
    bus.result_ready = 1'b1;
    bus.clear_counts = clr;
    @(posedge clock); #1;
    bus.result_ready = 1'b0;
    bus.clear_counts = 1'b0;
  endtask

  // Pops the scoreboard and compares one delivered result, then counters.
  task automatic check_result(input string tag, input int hold, input bit clr, output bit stable);
    logic [3:0] d; logic [15:0] m; logic c; exp_t e;
    get_result(hold, clr, d, m, c, stable);
    checks++;
    if (sb.size() == 0) begin failures++; $display("FAIL %s_scoreboard: queue empty, required one entry", tag); return; end
    e = sb.pop_front();
    if (clr) begin exp_img = 0; exp_mis = 0; end
    else begin
      if (exp_img < 65535) exp_img++;
      if (!e.correct && exp_mis < 65535) exp_mis++;
    end
    checks++; if (d !== e.digit) begin failures++; $display("FAIL %s_digit: got %0d required %0d", tag, d, e.digit); end
    checks++; if (m !== e.max) begin failures++; $display("FAIL %s_max: got %h required %h", tag, m, e.max); end
    checks++; if (c !== e.correct) begin failures++; $display("FAIL %s_correct: got %b required %b", tag, c, e.correct); end
    checks++; if (bus.image_count !== 16'(exp_img)) begin failures++; $display("FAIL %s_image_count: got %0d required %0d", tag, bus.image_count, exp_img); end
    checks++; if (bus.mispred_count !== 16'(exp_mis)) begin failures++; $display("FAIL %s_mispred_count: got %0d required %0d", tag, bus.mispred_count, exp_mis); end
    checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL %s_valid_drop: got %b required 0", tag, bus.result_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (bus.label_in_ready !== 1'b0) begin failures++; $display("FAIL rst_label_ready: got %b required 0", bus.label_in_ready); end
    checks++; if (bus.prediction_in_ready !== 1'b0) begin failures++; $display("FAIL rst_pred_ready: got %b required 0", bus.prediction_in_ready); end
    checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL rst_result_valid: got %b required 0", bus.result_valid); end
    checks++; if (bus.result_digit !== 4'd0 || bus.result_max !== 16'd0 || bus.result_correct !== 1'b0)
      begin failures++; $display("FAIL rst_result: got %0d/%h/%b required 0/0000/0", bus.result_digit, bus.result_max, bus.result_correct); end
    checks++; if (bus.image_count !== 16'd0 || bus.mispred_count !== 16'd0)
      begin failures++; $display("FAIL rst_counts: got %0d/%0d required 0/0", bus.image_count, bus.mispred_count); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (bus.label_in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_label_ready: got %b required 1", bus.label_in_ready); end
  endtask

  task automatic test_basic();
    img_t w = '{16'h0010, 16'h0020, 16'h0030, 16'h0400, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    bit st;
    send_image(4'd3, w, 0);
    checks++; if (bus.result_valid !== 1'b1) begin failures++; $display("FAIL basic_latency: result_valid=%b required 1", bus.result_valid); end
    checks++; if (bus.prediction_in_ready !== 1'b0) begin failures++; $display("FAIL basic_pred_ready: got %b required 0", bus.prediction_in_ready); end
    check_result("basic", 0, 1'b0, st);
    checks++; if (bus.label_in_ready !== 1'b1) begin failures++; $display("FAIL basic_idle: label_in_ready=%b required 1", bus.label_in_ready); end
  endtask

  task automatic test_tie();
    img_t w;
    bit st;
    for (int i = 0; i < 10; i++) w[i] = 16'hFF00;
    send_image(4'd7, w, 0);
    check_result("tie", 0, 1'b0, st);
  endtask

  task automatic test_negative_gaps();
    img_t w;
    bit st;
    for (int i = 0; i < 9; i++) w[i] = 16'h8000 + 16'(i);
    w[9] = 16'h0001;
    send_image(4'd9, w, 3);
    check_result("neg", 5, 1'b0, st);
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL neg_hold_stable: stable=%b required 1", st); end
  endtask

  task automatic test_clear_coincide();
    img_t w = '{16'h0005, 16'h0100, 16'h0003, 16'h0002, 16'h0001, 16'h0500, 16'h0, 16'h0, 16'h0, 16'h0};
    bit st;
    send_image(4'd1, w, 1);
    check_result("clr", 2, 1'b1, st);
    checks++; if (bus.label_in_ready !== 1'b1) begin failures++; $display("FAIL clr_idle: label_in_ready=%b required 1", bus.label_in_ready); end
  endtask

  task automatic test_reset_midway();
    img_t w = '{16'h0010, 16'h0020, 16'h0030, 16'h0100, 16'h0300, 16'h0040, 16'h0200, 16'h0, 16'h0, 16'h0};
    bit st;
    send_label(4'd2);
    send_word(16'h0000, 0);
    send_word(16'h7000, 0);
    send_word(16'h0001, 0);
    send_word(16'h0002, 0);
    do_reset(1);
    @(negedge clock);
    checks++; if (bus.label_in_ready !== 1'b1 || bus.prediction_in_ready !== 1'b0 || bus.result_valid !== 1'b0)
      begin failures++; $display("FAIL midrst_idle: lrdy/prdy/rv=%b%b%b required 100", bus.label_in_ready, bus.prediction_in_ready, bus.result_valid); end
    checks++; if (bus.image_count !== 16'(exp_img) || bus.mispred_count !== 16'(exp_mis))
      begin failures++; $display("FAIL midrst_counts: got %0d/%0d required %0d/%0d", bus.image_count, bus.mispred_count, exp_img, exp_mis); end
    send_image(4'd4, w, 1);
    check_result("midrst", 0, 1'b0, st);
  endtask

  task automatic test_bad_label();
    img_t w;
    bit st;
    for (int i = 0; i < 10; i++) w[i] = 16'($urandom_range(0, 65535));
    w[2] = 16'h7FFF;
    send_image(4'd12, w, 0);
    check_result("badlbl", 0, 1'b0, st);
  endtask

  task automatic test_back_to_back();
    img_t w;
    bit st;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) w[i] = 16'($urandom_range(0, 65535));
      send_image(4'($urandom_range(0, 9)), w, k);
      check_result("b2b", k, 1'b0, st);
      checks++; if (st !== 1'b1) begin failures++; $display("FAIL b2b_hold_stable: stable=%b required 1", st); end
    end
  endtask

  initial begin
    checks = 0; failures = 0; exp_img = 0; exp_mis = 0;
    reset = 1'b1;
    bus.prediction_in = '0; bus.prediction_in_valid = 1'b0;
    bus.label_in = '0; bus.label_in_valid = 1'b0;
    bus.result_ready = 1'b0; bus.clear_counts = 1'b0;
    test_reset();
    test_basic();
    test_tie();
    test_negative_gaps();
    test_clear_coincide();
    test_reset_midway();
    test_bad_label();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
